vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 144 ++++++++++++++
 tb/tb_vram_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM shared by video fetch, posted CPU writes and CPU reads on vga_clk.
// Grant order each cycle: video fetch, then write-FIFO drain, then CPU read.

module vram_wfifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         vga_clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Caller never pushes when full nor pops when empty.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (push) buf_q[wr_ptr] <= push_dat;
  end

  assign pop_dat = buf_q[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
endmodule

module vram_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              wfifo_full
);
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_RD} tag_t;

  logic [DATA_W-1:0]        mem [2**ADDR_W];
  logic [DATA_W-1:0]        mem_q;
  logic [DATA_W-1:0]        rdata_q;
  logic [ADDR_W-1:0]        last_vid_addr;
  logic                     vid_valid;
  tag_t                     tag_q;
  tag_t                     tag_d;
  logic                     vid_due;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_empty;
  logic                     rd_go;
  logic [ADDR_W+DATA_W-1:0] fifo_dat;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;

  assign {wr_addr, wr_data} = fifo_dat;

  assign vid_due   = !vid_valid || (vid_addr != last_vid_addr);
  assign fifo_push = cpu_req && cpu_we && !wfifo_full && !cpu_ack;
  assign fifo_pop  = !vid_due && !fifo_empty;
  // Reads wait for an empty FIFO so they always see every acked write.
  assign rd_go     = cpu_req && !cpu_we && fifo_empty && !vid_due && !cpu_ack;

  vram_wfifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .vga_clk  (vga_clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_dat ({cpu_addr, cpu_wdata}),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (wfifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    tag_d = TAG_NONE;
    if (vid_due)    tag_d = TAG_VID;
    else if (rd_go) tag_d = TAG_RD;
  end

  always_ff @(posedge vga_clk) begin
    if (fifo_pop)     mem[wr_addr] <= wr_data;
    else if (vid_due) mem_q <= mem[vid_addr];
    else if (rd_go)   mem_q <= mem[cpu_addr];
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_valid     <= 1'b0;
      last_vid_addr <= '0;
      tag_q         <= TAG_NONE;
      vid_data      <= '0;
      rdata_q       <= '0;
      cpu_ack       <= 1'b0;
    end else begin
      cpu_ack <= fifo_push || rd_go;
      tag_q   <= tag_d;
      if (vid_due) begin
        vid_valid     <= 1'b1;
        last_vid_addr <= vid_addr;
      end else if (fifo_pop && (wr_addr == last_vid_addr)) begin
        vid_valid <= 1'b0;
      end
      if (tag_q == TAG_VID) vid_data <= mem_q;
      if (tag_q == TAG_RD)  rdata_q  <= mem_q;
    end
  end

  // Read data is presented in the ack cycle straight from the memory register.
  assign cpu_rdata = (tag_q == TAG_RD) ? mem_q : rdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic against a byte-array memory model.
module tb_vram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          vga_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          wfifo_full;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int spin_end = 0;
  int ack_cyc = 0;
  logic [DW-1:0] ref_mem [2**AW];

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(4)) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .wfifo_full (wfifo_full)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Master holds the request through the ack cycle, then releases it.
  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; lat = 0;
    do begin tick(); lat++; end while (!cpu_ack && lat < 400);
    chk("wr_ack_seen", 16'(cpu_ack), 16'd1);
    ack_cyc = cyc;
    ref_mem[a] = d;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; lat = 0;
    do begin tick(); lat++; end while (!cpu_ack && lat < 400);
    chk("rd_ack_seen", 16'(cpu_ack), 16'd1);
    ack_cyc = cyc;
    d = cpu_rdata;
    tick();
    cpu_req = 1'b0;
  endtask

  // Keeps the video address moving so a fetch is due every cycle (rnd=0),
  // or wanders randomly over the low 16 bytes (rnd=1).
  task automatic vid_spin(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        if ($urandom_range(1, 0) == 1) vid_addr = AW'($urandom_range(15, 0));
      end else begin
        vid_addr = (vid_addr == 11'h400) ? 11'h410 : 11'h400;
      end
      tick();
    end
    spin_end = cyc;
  endtask

  int lat;
  logic [DW-1:0] rd;
  int rlen;
  bit rwr;
  logic [AW-1:0] ra;
  logic [DW-1:0] rdat;
  logic [DW-1:0] old_a [3];
  bit seen;

  initial begin
    #1;
    chk("rst_vid_data", 16'(vid_data), 16'h0);
    chk("rst_cpu_rdata", 16'(cpu_rdata), 16'h0);
    chk("rst_cpu_ack", 16'(cpu_ack), 16'h0);
    chk("rst_wfifo_full", 16'(wfifo_full), 16'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Preloaded character shows up two cycles after the address is presented.
    cpu_write(11'h400, 8'h41, lat);
    vid_addr = 11'h400;
    repeat (2) tick();
    chk("vid_fetch_2cyc", 16'(vid_data), 16'h41);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("vid_hold", 16'(vid_data), 16'h41);
    end

    // Write then read with a static video address.
    cpu_write(11'h555, 8'hAA, lat);
    chk("wr_lat", 16'(lat), 16'd1);
    cpu_read(11'h555, rd, lat);
    chk("rd_lat", 16'(lat), 16'd1);
    chk("rd_data_555", 16'(rd), 16'hAA);

    // Write to the displayed address forces a refetch.
    vid_addr = 11'h410;
    cpu_write(11'h410, 8'h11, lat);
    repeat (4) tick();
    chk("vid_410_init", 16'(vid_data), 16'h11);
    cpu_write(11'h410, 8'h7E, lat);
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      if (vid_data == 8'h7E) seen = 1'b1; else tick();
    end
    if (vid_data == 8'h7E) seen = 1'b1;
    chk("vid_refetch", 16'(seen), 16'd1);

    // Continuous video traffic fills the FIFO; the fifth write stalls.
    fork
      vid_spin(20, 1'b0);
      begin
        cpu_write(11'h100, 8'h11, lat);
        cpu_write(11'h101, 8'h22, lat);
        cpu_write(11'h102, 8'h33, lat);
        chk("full_after_3", 16'(wfifo_full), 16'd0);
        cpu_write(11'h100, 8'h44, lat);
        chk("full_after_4", 16'(wfifo_full), 16'd1);
        cpu_write(11'h103, 8'h55, lat);
        chk("wr5_stalled", 16'(ack_cyc > spin_end), 16'd1);
      end
    join
    cpu_read(11'h100, rd, lat);
    chk("order_100", 16'(rd), 16'h44);
    for (int i = 1; i < 4; i++) begin
      cpu_read(11'h100 + AW'(i), rd, lat);
      chk("order_10x", 16'(rd), 16'(ref_mem[11'h100 + AW'(i)]));
    end

    // Read behind pending writes waits for the drain and sees new data.
    fork
      vid_spin(12, 1'b0);
      begin
        cpu_write(11'h200, 8'h5A, lat);
        cpu_write(11'h201, 8'hC3, lat);
        cpu_read(11'h201, rd, lat);
        chk("rd_after_drain", 16'(ack_cyc > spin_end), 16'd1);
        chk("rd_new_data", 16'(rd), 16'hC3);
      end
    join

    // Reset with three posted writes pending.
    vid_addr = 11'h400;
    for (int i = 0; i < 3; i++) begin
      old_a[i] = DW'(8'h60 + i);
      cpu_write(11'h300 + AW'(i), old_a[i], lat);
    end
    cpu_read(11'h302, rd, lat);
    repeat (2) tick();
    fork
      vid_spin(12, 1'b0);
      begin
        for (int i = 0; i < 3; i++) cpu_write(11'h300 + AW'(i), DW'(8'hB0 + i), lat);
        chk("pend3_not_full", 16'(wfifo_full), 16'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_vid_data", 16'(vid_data), 16'h0);
        chk("arst_cpu_rdata", 16'(cpu_rdata), 16'h0);
        chk("arst_cpu_ack", 16'(cpu_ack), 16'h0);
        chk("arst_wfifo_full", 16'(wfifo_full), 16'h0);
      end
    join
    for (int i = 0; i < 3; i++) ref_mem[11'h300 + AW'(i)] = old_a[i];
    vid_addr = 11'h400;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    chk("first_fetch", 16'(vid_data), 16'h41);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_ack_after_rst", 16'(cpu_ack), 16'd0);
    end
    for (int i = 0; i < 3; i++) begin
      cpu_read(11'h300 + AW'(i), rd, lat);
      chk("mem_retained", 16'(rd), 16'(old_a[i]));
    end

    // Randomized traffic over a small address window shared with video.
    for (int i = 0; i < 16; i++) cpu_write(AW'(i), DW'($urandom), lat);
    for (int k = 0; k < 150; k++) begin
      rlen = $urandom_range(6, 0);
      rwr  = 1'($urandom_range(1, 0));
      ra   = AW'($urandom_range(15, 0));
      rdat = DW'($urandom);
      fork
        vid_spin(rlen, 1'b1);
        begin
          if (rwr) cpu_write(ra, rdat, lat);
          else begin
            cpu_read(ra, rd, lat);
            chk("rand_rd", 16'(rd), 16'(ref_mem[ra]));
          end
        end
      join
      repeat (6) tick();
      chk("rand_vid", 16'(vid_data), 16'(ref_mem[vid_addr]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
